// File: rtl/fetch_unit.sv
// Instruction fetch: PC register driving instruction memory, feeding a small FIFO toward decode.
// Latency: a word fetched at edge N appears on out_* after edge N; redirects flush the queue.
// Backpressure: a full queue with out_ready low freezes the PC and the queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    assign pop  = out_valid && out_ready;
    assign push = !redirect_valid && ((count < FULL) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= 32'd0;
                instr_mem[i] <= 32'd0;
            end
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                // Flush wins over any coincident handshake; the popped head counts as consumed.
                pc     <= {redirect_pc[31:2], 2'b00};
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]    <= pc;
                    instr_mem[wr_ptr] <= imem_rdata;
                    wr_ptr            <= wr_ptr + 1'b1;
                    pc                <= pc + 32'd4;
                    fetch_count       <= fetch_count + 32'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset; bits [1:0] are 0.
REQ-002 SHALL have parameter DEPTH, default 2, the fetch-queue entry count; a power of two, 2..8.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 imem_addr  output  32  byte address to instruction memory; equals the PC register combinationally.
REQ-007 imem_rdata  input  32  instruction word returned combinationally for imem_addr (word index imem_addr[31:2]).
REQ-008 redirect_valid  input  1  one-cycle request to change the PC (branch/jump/trap).
REQ-009 redirect_pc  input  32  target byte address for the redirect.
REQ-010 out_valid  output  1  queue head holds a valid instruction.
REQ-011 out_ready  input  1  decode stage accepts the head this cycle.
REQ-012 out_pc  output  32  PC of the head entry.
REQ-013 out_instr  output  32  instruction word of the head entry.
REQ-014 misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] was nonzero.
REQ-015 fetch_count  output  32  number of words enqueued since reset.

Function
REQ-016 PC register SHALL hold a word-aligned address; imem_addr = PC, no added latency.
REQ-017 push condition: !redirect_valid && (count < DEPTH || pop); on push, enqueue {PC, imem_rdata} and PC <= PC + 4.
REQ-018 pop condition: out_valid && out_ready; pop removes the head at the clock edge.
REQ-019 Simultaneous push and pop SHALL be legal when the queue is full or partially full; count is unchanged.
REQ-020 When the queue is full and there is no pop, PC and the queue SHALL hold; imem_addr stays stable.
REQ-021 out_valid = (count != 0); out_pc and out_instr SHALL be driven from head-entry registers, never from imem_rdata.
REQ-022 A word fetched at edge N SHALL be visible on out_* after edge N (one-cycle latency when the queue was empty).
REQ-023 A redirect SHALL have priority over push and pop: on its edge, flush the queue (count=0), set PC <= {redirect_pc[31:2],2'b00}, and make no push.
REQ-024 A handshake (out_valid && out_ready) coinciding with a redirect SHALL count as consumed by decode; the queue is still fully flushed.
REQ-025 On a redirect, misalign_err SHALL be registered high for exactly one cycle if redirect_pc[1:0] != 0; otherwise it is 0.
REQ-026 PC increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
REQ-027 fetch_count SHALL increment by 1 per push, wrap modulo 2^32, and not be cleared by a redirect.
REQ-028 Queue read/write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-029 Back-to-back redirects SHALL each take effect; the last one determines the PC.

Reset
REQ-030 While rst=1, asynchronously: PC=RESET_PC, count=0, pointers=0, out_valid=0, out_pc=0, out_instr=0, misalign_err=0, fetch_count=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries immediately, with no partial push.
REQ-032 At the first edge after rst deasserts, the word at RESET_PC SHALL be enqueued (out_valid=1 after that edge).

Verification
REQ-033 Reset, then mem[0]=32'h0000_0013 with out_ready=1 -> after edge 1: out_valid=1, out_pc=0, out_instr=32'h0000_0013; PC sequence 0,4,8,... one per cycle.
REQ-034 out_ready=0 for 5 cycles, DEPTH=2 -> out_valid=1, queue holds PC 0 and PC 4, imem_addr frozen at 8, fetch_count=2.
REQ-035 Queue full with out_ready=1 -> simultaneous pop and push each cycle; out_pc advances by 4 per cycle and count stays 2.
REQ-036 redirect_valid=1, redirect_pc=32'h0000_0100 with a non-empty queue -> next cycle out_valid=0, imem_addr=32'h100; the cycle after, out_pc=32'h100.
REQ-037 redirect_pc=32'h0000_0102 -> misalign_err=1 for one cycle and PC=32'h100.
REQ-038 redirect to 32'hFFFF_FFFC, then free-run -> out_pc sequence FFFF_FFFC, 0000_0000; rst pulse mid-run -> out_valid=0 immediately and PC=RESET_PC.
